da_rom_sequencer: RTL and testbench

Bit-serial distributed-arithmetic (DA) sequencer for one DCT output term. It accepts a group of four signed samples plus an offset, and walks the sample bits LSB-first over DATA_W cycles. Each cycle it forms the 3-bit address for the external symmetric coefficient ROM and accumulates the ROM word with shift-add weighting. The result is presented on a valid/ready output. It sits between the DCT input buffer and one coefficient-ROM instance, and is the sole driver of that ROM's cs/addr.

---
 rtl/da_rom_sequencer.sv | 151 +++++++++++++++
 tb/tb_da_rom_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/da_rom_sequencer.sv
// Bit-serial distributed-arithmetic sequencer for one DCT output term.
// Walks four signed samples LSB-first, addressing a symmetric coefficient ROM and shift-accumulating.
module da_rom_sequencer #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = DATA_W + COEF_W + 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] x0,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    input  logic [DATA_W-1:0] x3,
    input  logic [ACC_W-1:0]  offset,
    output logic              rom_cs,
    output logic [2:0]        rom_addr,
    input  logic [16:0]       rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  y,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int JW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [JW-1:0] J_LAST = JW'(DATA_W - 1);

    state_t                   state_reg;
    logic [JW-1:0]            j_reg;
    logic signed [ACC_W-1:0]  acc_reg;
    logic                     in_ready_reg;
    logic                     out_valid_reg;
    logic                     busy_reg;
    logic                     rom_cs_reg;

    logic [DATA_W-1:0]        x_in [4];
    logic [3:0]               lsb;
    logic                     load;
    logic                     shift_en;

    assign x_in[0] = x0;
    assign x_in[1] = x1;
    assign x_in[2] = x2;
    assign x_in[3] = x3;

    assign load     = (state_reg == IDLE) && in_valid;
    assign shift_en = (state_reg == RUN);

    // One shift register per sample lane; bit 0 is the bit being processed this cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [DATA_W-1:0] sreg_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sreg_reg <= '0;
                end else if (load) begin
                    sreg_reg <= x_in[gi];
                end else if (shift_en) begin
                    sreg_reg <= sreg_reg >> 1;
                end
            end

            assign lsb[gi] = sreg_reg[0];
        end
    endgenerate

    // Bits of the ROM bus above the coefficient width carry no information.
    generate
        if (COEF_W < 17) begin : g_rom_hi
            logic unused_rom_hi;
            assign unused_rom_hi = ^rom_data[16:COEF_W];
        end
    endgenerate

    // Symmetric ROM: the address is taken relative to x0's bit, which then selects the sign.
    logic signed [ACC_W-1:0] coef_ext;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] term_shift;
    logic signed [ACC_W-1:0] acc_next;

    assign coef_ext   = ACC_W'($signed(rom_data[COEF_W-1:0]));
    assign term       = lsb[0] ? -coef_ext : coef_ext;
    assign term_shift = term <<< j_reg;
    assign acc_next   = (j_reg == J_LAST) ? (acc_reg - term_shift) : (acc_reg + term_shift);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            j_reg         <= '0;
            acc_reg       <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            rom_cs_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        state_reg    <= RUN;
                        acc_reg      <= offset;
                        j_reg        <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        rom_cs_reg   <= 1'b1;
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    j_reg   <= j_reg + 1'b1;
                    if (j_reg == J_LAST) begin
                        state_reg     <= DONE;
                        rom_cs_reg    <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    rom_cs_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign busy      = busy_reg;
    assign rom_cs    = rom_cs_reg;
    assign rom_addr  = rom_cs_reg ? {lsb[1] ^ lsb[0], lsb[2] ^ lsb[0], lsb[3] ^ lsb[0]} : 3'b000;
    assign y         = acc_reg;

endmodule

// File: tb/tb_da_rom_sequencer.sv
// Bench for da_rom_sequencer: fixed vectors, multi-cycle corner sequences and random groups
// checked against an arithmetic model of the DA sum.
module tb_da_rom_sequencer;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int ACC_W  = DATA_W + COEF_W + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic [ACC_W-1:0]  offset = '0;
    logic              rom_cs;
    logic [2:0]        rom_addr;
    logic [16:0]       rom_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [ACC_W-1:0]  y;
    logic              busy;
    logic              rom_junk = 1'b0;

    int tests = 0;
    int fails = 0;

    da_rom_sequencer #(.DATA_W(DATA_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .offset(offset),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy)
    );

    always #5 clk = ~clk;

    // Coefficient ROM contents; entries 0, 4 and 7 are fixed by the known DCT term.
    function automatic logic [15:0] rom_word(input logic [2:0] a);
        case (a)
            3'd0: rom_word = 16'hE333;
            3'd1: rom_word = 16'h1234;
            3'd2: rom_word = 16'h0F00;
            3'd3: rom_word = 16'h7FFF;
            3'd4: rom_word = 16'h21F8;
            3'd5: rom_word = 16'h8000;
            3'd6: rom_word = 16'hC0DE;
            default: rom_word = 16'hF93E;
        endcase
    endfunction

    // Bit 16 is random junk the sequencer must ignore.
    always_comb rom_data = {rom_junk, rom_word(rom_addr)};
    always @(negedge clk) rom_junk <= 1'($urandom);

    function automatic logic [ACC_W-1:0] ref_y(input logic [15:0] a, b, c, d,
                                               input logic [ACC_W-1:0] off);
        longint acc;
        acc = longint'(off);
        for (int j = 0; j < DATA_W; j++) begin
            logic [2:0] ad;
            longint r, w, s;
            ad = {b[j] ^ a[j], c[j] ^ a[j], d[j] ^ a[j]};
            r = longint'($signed(rom_word(ad)));
            s = a[j] ? -1 : 1;
            w = (j == DATA_W - 1) ? -(longint'(1) << j) : (longint'(1) << j);
            acc = acc + w * s * r;
        end
        return acc[ACC_W-1:0];
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic run_group(input logic [15:0] a, b, c, d, input logic [ACC_W-1:0] off,
                             input logic [ACC_W-1:0] exp, input int hold, input string nm);
        int n;
        @(negedge clk);
        x0 = a; x1 = b; x2 = c; x3 = d; offset = off; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_ready_wait"}, 64'(in_ready), 64'(1));
        @(negedge clk);
        // Scramble inputs: only the accepting edge may sample them.
        in_valid = 1'b0;
        x0 = 16'($urandom); x1 = 16'($urandom); x2 = 16'($urandom); x3 = 16'($urandom);
        offset = ACC_W'({$urandom, $urandom});
        n = 1;
        while (!out_valid && n < 100) begin
            if (n - 1 < DATA_W) begin
                int j;
                logic [2:0] ea;
                j = n - 1;
                ea = {b[j] ^ a[j], c[j] ^ a[j], d[j] ^ a[j]};
                check($sformatf("%s_cs_j%0d", nm, j), 64'(rom_cs), 64'(1));
                check($sformatf("%s_addr_j%0d", nm, j), 64'(rom_addr), 64'(ea));
            end
            @(negedge clk);
            n++;
        end
        check({nm, "_latency"}, 64'(n), 64'(DATA_W + 1));
        check({nm, "_y"}, 64'(y), 64'(exp));
        check({nm, "_cs_done"}, 64'({rom_cs, rom_addr, busy, in_ready}), 64'(4'b0010));
        for (int h = 0; h < hold; h++) begin
            in_valid = (h % 2 == 0);
            x0 = 16'($urandom);
            @(negedge clk);
            check($sformatf("%s_hold%0d", nm, h), 64'({y, out_valid, in_ready, busy}),
                  64'({exp, 3'b101}));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({nm, "_release"}, 64'({out_valid, in_ready, busy}), 64'(3'b010));
        @(negedge clk);
        check({nm, "_idle"}, 64'({busy, in_ready}), 64'(2'b01));
        $display("[TB] group %s x0=%h x1=%h x2=%h x3=%h off=%0d y=%0d exp=%0d", nm, a, b, c, d,
                 $signed(off), $signed(y), $signed(exp));
    endtask

    typedef struct {
        logic [15:0]      a, b, c, d;
        logic [ACC_W-1:0] off;
        logic [ACC_W-1:0] y;
        int               hold;
        string            nm;
    } vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int n, last_acc, accepts;
        bit seen_valid;

        vt[0] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, ACC_W'(0),   ACC_W'(7373),  0, "zeros"};
        vt[1] = '{16'h0000, 16'h0001, 16'h0000, 16'h0000, ACC_W'(0),   ACC_W'(23442), 0, "x1_one"};
        vt[2] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000, ACC_W'(0),   ACC_W'(-1730), 0, "x0_m1"};
        vt[3] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, ACC_W'(0),   ACC_W'(16476), 1, "x0_one"};
        vt[4] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, ACC_W'(100), ACC_W'(7473),  5, "backpressure"};
        vt[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, ACC_W'(0),   ACC_W'(-7373), 2, "all_m1"};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({in_ready, out_valid, rom_cs, rom_addr, busy}), 64'(7'b1000000));
        check("reset_y", 64'(y), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_group(vt[i].a, vt[i].b, vt[i].c, vt[i].d, vt[i].off, vt[i].y, vt[i].hold, vt[i].nm);

        // Reset asserted at RUN cycle j=7
        @(negedge clk);
        x0 = '0; x1 = '0; x2 = '0; x3 = '0; offset = '0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("midrun_busy", 64'({busy, rom_cs}), 64'(2'b11));
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", 64'({in_ready, out_valid, rom_cs, rom_addr, busy}),
              64'(7'b1000000));
        check("midrun_reset_y", 64'(y), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen_valid = 1'b1;
        end
        check("midrun_no_result", 64'(seen_valid), 64'(0));
        $display("[TB] reset mid-run at j=7 handled");
        run_group('0, '0, '0, '0, '0, ACC_W'(7373), 0, "after_reset");

        // Back-to-back accepts with in_valid and out_ready held high
        @(negedge clk);
        x0 = '0; x1 = '0; x2 = '0; x3 = '0; offset = ACC_W'(100);
        in_valid = 1'b1; out_ready = 1'b1;
        last_acc = -1; accepts = 0;
        for (int i = 0; i < 80; i++) begin
            if (in_ready) begin
                if (last_acc >= 0) check("b2b_spacing", 64'(i - last_acc), 64'(DATA_W + 2));
                last_acc = i;
                accepts++;
            end
            if (out_valid) check("b2b_y", 64'(y), 64'(7473));
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b_accepts", 64'(accepts >= 4), 64'(1));
        $display("[TB] back-to-back: %0d accepts observed", accepts);
        n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b2b_drain", 64'(busy), 64'(0));
        out_ready = 1'b0;

        // Random groups against the arithmetic model
        for (int i = 0; i < 20; i++) begin
            logic [15:0] a, b, c, d;
            logic [ACC_W-1:0] off;
            a = 16'($urandom); b = 16'($urandom); c = 16'($urandom); d = 16'($urandom);
            off = ACC_W'({$urandom, $urandom});
            run_group(a, b, c, d, off, ref_y(a, b, c, d, off), int'($urandom_range(0, 3)),
                      $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
